bp_perf_monitor: RTL and testbench

Synthesizable branch-predictor performance monitor and the hardware successor to the simulation-only predictor logger. It counts predict-side and update-side events across all fetch and update ports each cycle. Counting runs in cumulative, windowed, or one-shot mode, with saturating counters, sticky overflow flags, a per-window snapshot bank and a mispredict-threshold alarm. It sits beside the predictor and is read through a registered select/data port by debug or CSR logic.

---
 rtl/bp_perf_monitor.sv | 183 ++++++++++++++++++
 tb/tb_bp_perf_monitor.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_perf_monitor.sv
// Branch-predictor performance monitor: eight saturating event counters with cumulative,
// windowed and one-shot modes, a per-window snapshot bank, sticky alarm and registered read port.
module bp_perf_monitor #(
  parameter int unsigned NUM_FETCH   = 5,
  parameter int unsigned NUM_UPD     = 3,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned WINDOW_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_FETCH-1:0]   pred_valid_i,
  input  logic [NUM_FETCH-1:0]   pred_sel_gshare_i,
  input  logic [NUM_UPD-1:0]     upd_valid_i,
  input  logic [NUM_UPD-1:0]     upd_mispred_i,
  input  logic [NUM_UPD-1:0]     upd_restore_ghr_i,
  input  logic [2*NUM_UPD-1:0]   upd_redirect_cause_i,
  input  logic                   enable_i,
  input  logic [1:0]             mode_i,
  input  logic                   clear_i,
  input  logic [CNT_WIDTH-1:0]   thresh_i,
  input  logic                   rd_src_i,
  input  logic [2:0]             rd_sel_i,
  output logic [CNT_WIDTH-1:0]   rd_data_o,
  output logic [7:0]             ovf_o,
  output logic                   snap_valid_o,
  output logic                   done_o,
  output logic                   alarm_o,
  output logic                   busy_o
);

  localparam int unsigned NumEv = 8;
  localparam int unsigned IncW  = CNT_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0]   CntMax  = '1;
  localparam logic [WINDOW_LOG2-1:0] WinLast = '1;
  localparam logic [1:0] ModeWin = 2'd1;
  localparam logic [1:0] ModeOne = 2'd2;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [WINDOW_LOG2-1:0] win_q, win_d;
  logic [CNT_WIDTH-1:0]   live_q [NumEv];
  logic [CNT_WIDTH-1:0]   live_d [NumEv];
  logic [CNT_WIDTH-1:0]   snap_q [NumEv];
  logic [CNT_WIDTH-1:0]   snap_d [NumEv];
  logic [NumEv-1:0]       ovf_q, ovf_d;
  logic                   alarm_q, alarm_d;
  logic                   snap_valid_q, snap_valid_d;
  logic [CNT_WIDTH-1:0]   rd_data_q;

  logic [IncW-1:0]        inc [NumEv];
  logic [IncW-1:0]        sum [NumEv];
  logic [CNT_WIDTH-1:0]   sat [NumEv];
  logic [NumEv-1:0]       sat_hit;
  logic                   start, count, win_end, snap_take;

  // Per-cycle event increments across all ports.
  always_comb begin
    for (int e = 0; e < NumEv; e++) inc[e] = '0;
    for (int i = 0; i < NUM_FETCH; i++) begin
      inc[0] = inc[0] + IncW'(pred_valid_i[i]);
      inc[1] = inc[1] + IncW'(pred_valid_i[i] & pred_sel_gshare_i[i]);
      inc[2] = inc[2] + IncW'(pred_valid_i[i] & ~pred_sel_gshare_i[i]);
    end
    for (int j = 0; j < NUM_UPD; j++) begin
      inc[3] = inc[3] + IncW'(upd_valid_i[j]);
      inc[4] = inc[4] + IncW'(upd_valid_i[j] & upd_mispred_i[j]);
      inc[5] = inc[5] + IncW'(upd_valid_i[j] & upd_mispred_i[j] &
                              (upd_redirect_cause_i[2*j +: 2] == 2'd0));
      inc[6] = inc[6] + IncW'(upd_valid_i[j] & upd_mispred_i[j] &
                              (upd_redirect_cause_i[2*j +: 2] == 2'd1));
      inc[7] = inc[7] + IncW'(upd_valid_i[j] & upd_restore_ghr_i[j]);
    end
  end

  always_comb begin
    for (int e = 0; e < NumEv; e++) begin
      sum[e]     = {1'b0, live_q[e]} + inc[e];
      sat_hit[e] = (sum[e] >= {1'b0, CntMax});
      sat[e]     = sat_hit[e] ? CntMax : sum[e][CNT_WIDTH-1:0];
    end
  end

  assign start     = (state_q == StIdle) && enable_i;
  assign count     = (state_q == StRun) && enable_i && !clear_i;
  assign win_end   = count && (win_q == WinLast);
  assign snap_take = win_end && ((mode_q == ModeWin) || (mode_q == ModeOne));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (enable_i) state_d = StRun;
      StRun: begin
        if (!enable_i) state_d = StIdle;
        else if (snap_take && (mode_q == ModeOne)) state_d = StDone;
      end
      StDone: if (clear_i || !enable_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o = (state_q == StRun);
    done_o = (state_q == StDone);
  end

  // Datapath next state; clear overrides counting, window end and mode-entry clearing.
  always_comb begin
    live_d       = live_q;
    snap_d       = snap_q;
    win_d        = win_q;
    ovf_d        = ovf_q;
    alarm_d      = alarm_q;
    mode_d       = mode_q;
    snap_valid_d = 1'b0;
    if (start) mode_d = mode_i;
    if (clear_i) begin
      for (int e = 0; e < NumEv; e++) begin
        live_d[e] = '0;
        snap_d[e] = '0;
      end
      win_d   = '0;
      ovf_d   = '0;
      alarm_d = 1'b0;
    end else begin
      if (start) begin
        win_d = '0;
        if ((mode_i == ModeWin) || (mode_i == ModeOne)) begin
          for (int e = 0; e < NumEv; e++) live_d[e] = '0;
        end
      end
      if (count) begin
        win_d = win_q + WINDOW_LOG2'(1);
        ovf_d = ovf_q | sat_hit;
        for (int e = 0; e < NumEv; e++) live_d[e] = sat[e];
        if (snap_take) begin
          for (int e = 0; e < NumEv; e++) begin
            snap_d[e] = sat[e];
            live_d[e] = '0;
          end
          snap_valid_d = 1'b1;
          alarm_d      = alarm_q | (sat[4] > thresh_i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NumEv; e++) begin
        live_q[e] <= '0;
        snap_q[e] <= '0;
      end
      win_q        <= '0;
      ovf_q        <= '0;
      alarm_q      <= 1'b0;
      mode_q       <= 2'd0;
      snap_valid_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      live_q       <= live_d;
      snap_q       <= snap_d;
      win_q        <= win_d;
      ovf_q        <= ovf_d;
      alarm_q      <= alarm_d;
      mode_q       <= mode_d;
      snap_valid_q <= snap_valid_d;
      rd_data_q    <= rd_src_i ? snap_q[rd_sel_i] : live_q[rd_sel_i];
    end
  end

  assign rd_data_o    = rd_data_q;
  assign ovf_o        = ovf_q;
  assign alarm_o      = alarm_q;
  assign snap_valid_o = snap_valid_q;

endmodule

// File: tb/tb_bp_perf_monitor.sv
// Directed bench for bp_perf_monitor: table-driven event decode plus hand-written mode,
// alarm, saturation, clear and reset sequences.
module tb_bp_perf_monitor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] pred_valid_i, pred_sel_gshare_i;
  logic [2:0] upd_valid_i, upd_mispred_i, upd_restore_ghr_i;
  logic [5:0] upd_redirect_cause_i;
  logic       enable_i, clear_i, rd_src_i;
  logic [1:0] mode_i;
  logic [7:0] thresh_i;
  logic [2:0] rd_sel_i;
  logic [7:0] rd_data_o, ovf_o;
  logic       snap_valid_o, done_o, alarm_o, busy_o;

  int n_cmp = 0;
  int n_fail = 0;

  bp_perf_monitor #(
    .NUM_FETCH  (5),
    .NUM_UPD    (3),
    .CNT_WIDTH  (8),
    .WINDOW_LOG2(3)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pred_valid_i        (pred_valid_i),
    .pred_sel_gshare_i   (pred_sel_gshare_i),
    .upd_valid_i         (upd_valid_i),
    .upd_mispred_i       (upd_mispred_i),
    .upd_restore_ghr_i   (upd_restore_ghr_i),
    .upd_redirect_cause_i(upd_redirect_cause_i),
    .enable_i            (enable_i),
    .mode_i              (mode_i),
    .clear_i             (clear_i),
    .thresh_i            (thresh_i),
    .rd_src_i            (rd_src_i),
    .rd_sel_i            (rd_sel_i),
    .rd_data_o           (rd_data_o),
    .ovf_o               (ovf_o),
    .snap_valid_o        (snap_valid_o),
    .done_o              (done_o),
    .alarm_o             (alarm_o),
    .busy_o              (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] pv, sg;
    logic [2:0] uv, um, ur;
    logic [5:0] cause;
    int         exp [8];
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic zero_ev();
    pred_valid_i = '0; pred_sel_gshare_i = '0;
    upd_valid_i = '0; upd_mispred_i = '0; upd_restore_ghr_i = '0;
    upd_redirect_cause_i = '0;
  endtask

  task automatic rd(input logic src, input logic [2:0] sel, output logic [7:0] d);
    rd_src_i = src;
    rd_sel_i = sel;
    tick();
    d = rd_data_o;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic start(input logic [1:0] m);
    mode_i   = m;
    enable_i = 1'b1;
    tick();
  endtask

  task automatic go_idle();
    enable_i = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    logic       sv_seen;
    vecs[0] = '{5'b11111, 5'b00111, 3'b000, 3'b000, 3'b000, 6'b000000, '{5, 3, 2, 0, 0, 0, 0, 0}};
    vecs[1] = '{5'b10101, 5'b11100, 3'b111, 3'b101, 3'b010, 6'b000001, '{3, 2, 1, 3, 2, 1, 1, 1}};
    vecs[2] = '{5'b00000, 5'b11111, 3'b011, 3'b111, 3'b111, 6'b001110, '{0, 0, 0, 2, 2, 0, 0, 2}};
    vecs[3] = '{5'b01010, 5'b00000, 3'b110, 3'b110, 3'b000, 6'b010011, '{2, 0, 2, 2, 2, 1, 1, 0}};

    rst_n = 1'b0;
    zero_ev();
    enable_i = 0; clear_i = 0; mode_i = 0; thresh_i = 8'd7; rd_src_i = 0; rd_sel_i = 0;
    tick(); tick();
    chk("reset_rd_data", rd_data_o, 0);
    chk("reset_ovf", ovf_o, 0);
    chk("reset_flags", {snap_valid_o, done_o, alarm_o, busy_o}, 4'b0000);
    rst_n = 1'b1;
    tick();
    rd(1'b0, 3'd0, d);
    chk("reset_live0", d, 0);

    // Event decode, one counted cycle per vector in cumulative mode.
    for (int v = 0; v < 4; v++) begin
      pulse_clear();
      start(2'd0);
      pred_valid_i = vecs[v].pv; pred_sel_gshare_i = vecs[v].sg;
      upd_valid_i = vecs[v].uv; upd_mispred_i = vecs[v].um; upd_restore_ghr_i = vecs[v].ur;
      upd_redirect_cause_i = vecs[v].cause;
      tick();
      zero_ev();
      go_idle();
      for (int e = 0; e < 8; e++) begin
        rd(1'b0, 3'(e), d);
        chk($sformatf("vec%0d_ev%0d", v, e), d, vecs[v].exp[e]);
      end
    end

    // Cumulative: 10 cycles, 5 preds each, 3 gshare.
    pulse_clear();
    start(2'd0);
    pred_valid_i = 5'b11111; pred_sel_gshare_i = 5'b00111;
    sv_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      sv_seen = sv_seen | snap_valid_o;
    end
    chk("cum_busy", busy_o, 1);
    zero_ev();
    go_idle();
    chk("cum_snap_valid_never", sv_seen, 0);
    chk("cum_idle_busy", busy_o, 0);
    rd(1'b0, 3'd0, d); chk("cum_pred_total", d, 50);
    rd(1'b0, 3'd1, d); chk("cum_pred_gshare", d, 30);
    rd(1'b0, 3'd2, d); chk("cum_pred_bimodal", d, 20);
    chk("cum_ovf", ovf_o, 0);

    // Windowed: 3 updates/cycle, 1 branch mispredict/cycle, threshold 7.
    pulse_clear();
    thresh_i = 8'd7;
    start(2'd1);
    upd_valid_i = 3'b111; upd_mispred_i = 3'b001; upd_redirect_cause_i = 6'b000000;
    for (int k = 0; k < 7; k++) tick();
    chk("win_sv_before", snap_valid_o, 0);
    chk("win_alarm_before", alarm_o, 0);
    tick();
    chk("win_sv_pulse", snap_valid_o, 1);
    chk("win_alarm_set", alarm_o, 1);
    zero_ev();
    rd(1'b0, 3'd3, d); chk("win_live_cleared", d, 0);
    chk("win_sv_one_cycle", snap_valid_o, 0);
    go_idle();
    rd(1'b1, 3'd3, d); chk("win_snap_upd_total", d, 24);
    rd(1'b1, 3'd4, d); chk("win_snap_upd_misp", d, 8);
    rd(1'b1, 3'd5, d); chk("win_snap_branch", d, 8);
    rd(1'b1, 3'd6, d); chk("win_snap_jalr", d, 0);
    start(2'd1);
    for (int k = 0; k < 8; k++) tick();
    chk("win2_sv_pulse", snap_valid_o, 1);
    chk("win2_alarm_sticky", alarm_o, 1);
    go_idle();
    rd(1'b1, 3'd4, d); chk("win2_snap_misp", d, 0);
    pulse_clear();
    chk("alarm_cleared", alarm_o, 0);
    rd(1'b1, 3'd3, d); chk("clear_snap", d, 0);

    // One-shot: one jalr mispredict per cycle.
    thresh_i = 8'd200;
    pulse_clear();
    start(2'd2);
    upd_valid_i = 3'b001; upd_mispred_i = 3'b001; upd_redirect_cause_i = 6'b000001;
    for (int k = 0; k < 7; k++) tick();
    chk("one_done_before", done_o, 0);
    tick();
    chk("one_done", done_o, 1);
    chk("one_not_busy", busy_o, 0);
    chk("one_sv", snap_valid_o, 1);
    for (int k = 0; k < 3; k++) tick();
    rd(1'b1, 3'd6, d); chk("one_snap_jalr", d, 8);
    rd(1'b1, 3'd5, d); chk("one_snap_branch", d, 0);
    rd(1'b0, 3'd6, d); chk("one_live_frozen", d, 0);
    chk("one_alarm", alarm_o, 0);
    zero_ev();
    go_idle();
    chk("one_done_cleared", done_o, 0);
    chk("one_idle_busy", busy_o, 0);

    // Saturation at 8 bits: 52 cycles of 5 bimodal predictions.
    pulse_clear();
    start(2'd0);
    pred_valid_i = 5'b11111;
    for (int k = 0; k < 52; k++) tick();
    zero_ev();
    go_idle();
    rd(1'b0, 3'd0, d); chk("sat_pred_total", d, 255);
    rd(1'b0, 3'd1, d); chk("sat_pred_gshare", d, 0);
    chk("sat_ovf", ovf_o, 8'h05);
    pulse_clear();
    chk("sat_ovf_cleared", ovf_o, 0);

    // Clear on the window-end cycle, then a fresh full window.
    start(2'd1);
    upd_valid_i = 3'b111; upd_mispred_i = 3'b111;
    for (int k = 0; k < 7; k++) tick();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("clr_we_no_sv", snap_valid_o, 0);
    chk("clr_we_busy", busy_o, 1);
    upd_mispred_i = 3'b000; upd_valid_i = 3'b001;
    rd(1'b0, 3'd3, d); chk("clr_we_live", d, 0);
    rd(1'b1, 3'd3, d); chk("clr_we_snap", d, 0);
    for (int k = 0; k < 5; k++) tick();
    chk("fresh_sv_before", snap_valid_o, 0);
    tick();
    chk("fresh_sv", snap_valid_o, 1);
    zero_ev();
    go_idle();
    rd(1'b1, 3'd3, d); chk("fresh_snap_upd_total", d, 8);

    // Asynchronous reset in the middle of a run.
    pulse_clear();
    start(2'd0);
    pred_valid_i = 5'b11111;
    rd_src_i = 1'b0; rd_sel_i = 3'd0;
    tick(); tick(); tick();
    chk("pre_rst_rd", rd_data_o, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rd", rd_data_o, 0);
    chk("async_rst_flags", {snap_valid_o, done_o, alarm_o, busy_o}, 4'b0000);
    chk("async_rst_ovf", ovf_o, 0);
    zero_ev();
    enable_i = 1'b0;
    rst_n = 1'b1;
    tick();
    rd(1'b0, 3'd0, d); chk("post_rst_live", d, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
